// File: rtl/cp0_irq_ctrl.sv
// CP0 register file (STATUS/BASE/CAUSE/EPC) with a vectored,
// edge-triggered, lowest-index-first interrupt controller.
module cp0_irq_ctrl #(
    parameter int DATA_W  = 32,
    parameter int NUM_IRQ = 8,
    parameter int IDX_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [4:0]         c0_rd_addr,
    output logic [DATA_W-1:0]  c0_r_data,
    input  logic [4:0]         c0_wr_addr,
    input  logic [DATA_W-1:0]  c0_w_data,
    input  logic               c0_reg_we,
    input  logic [31:0]        pc_i,
    input  logic               int_ack_i,
    input  logic               eret_i,
    output logic               int_req_o,
    output logic [31:0]        vector_o,
    output logic [31:0]        epc_o,
    output logic               in_handler_o
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] HANDLER = 1'b1;

    localparam logic [4:0] A_STATUS = 5'd11;
    localparam logic [4:0] A_BASE   = 5'd12;
    localparam logic [4:0] A_CAUSE  = 5'd13;
    localparam logic [4:0] A_EPC    = 5'd14;

    logic [0:0]         state_q, state_d;
    logic               ie_q, ie_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] irq_d_q;
    logic               armed_q;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  base_q, base_d;
    logic [DATA_W-1:0]  epc_q, epc_d;

    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] elig;
    logic [NUM_IRQ-1:0] sel_oh;
    logic [IDX_W-1:0]   sel;
    logic [IDX_W-1:0]   vec_idx;
    logic               ack_fire;
    logic               eret_fire;
    logic               wr_status, wr_base, wr_cause, wr_epc;

    // armed_q suppresses a bogus edge from a line held high across reset
    assign rise   = irq_i & ~irq_d_q & {NUM_IRQ{armed_q}};
    assign elig   = pend_q & mask_q;
    assign sel_oh = elig & (~elig + NUM_IRQ'(1));

    always_comb begin
        sel = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (elig[k]) begin
                sel = IDX_W'(k);
            end
        end
    end

    assign int_req_o    = ie_q && (elig != '0) && (state_q == IDLE);
    assign in_handler_o = (state_q == HANDLER);
    assign ack_fire     = int_ack_i && int_req_o;
    assign eret_fire    = eret_i && (state_q == HANDLER);

    assign vec_idx  = (state_q == HANDLER) ? idx_q : sel;
    assign vector_o = 32'(base_q) + 32'({vec_idx, 3'b000});
    assign epc_o    = 32'(epc_q);

    assign wr_status = c0_reg_we && (c0_wr_addr == A_STATUS);
    assign wr_base   = c0_reg_we && (c0_wr_addr == A_BASE);
    assign wr_cause  = c0_reg_we && (c0_wr_addr == A_CAUSE);
    assign wr_epc    = c0_reg_we && (c0_wr_addr == A_EPC);

    always_comb begin
        c0_r_data = '0;
        case (c0_rd_addr)
            A_STATUS: begin
                c0_r_data[0]            = ie_q;
                c0_r_data[8+:NUM_IRQ]   = mask_q;
            end
            A_BASE:  c0_r_data = base_q;
            A_CAUSE: begin
                c0_r_data[2+:IDX_W]     = idx_q;
                c0_r_data[8+:NUM_IRQ]   = pend_q;
            end
            A_EPC:   c0_r_data = epc_q;
            default: c0_r_data = '0;
        endcase
    end

    // Later assignments take priority: mtc0, then ack/eret, then new edges
    always_comb begin
        state_d = state_q;
        ie_d    = ie_q;
        mask_d  = mask_q;
        pend_d  = pend_q;
        idx_d   = idx_q;
        base_d  = base_q;
        epc_d   = epc_q;

        if (wr_status) begin
            ie_d   = c0_w_data[0];
            mask_d = c0_w_data[8+:NUM_IRQ];
        end
        if (wr_base) begin
            base_d = {c0_w_data[DATA_W-1:3], 3'b000};
        end
        if (wr_cause) begin
            pend_d = pend_q & ~c0_w_data[8+:NUM_IRQ];
        end
        if (wr_epc) begin
            epc_d = c0_w_data;
        end

        if (ack_fire) begin
            state_d = HANDLER;
            epc_d   = DATA_W'(pc_i);
            idx_d   = sel;
            ie_d    = 1'b0;
            pend_d  = pend_d & ~sel_oh;
        end else if (eret_fire) begin
            state_d = IDLE;
            ie_d    = 1'b1;
        end

        pend_d = pend_d | rise;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ie_q    <= 1'b0;
            mask_q  <= '0;
            pend_q  <= '0;
            irq_d_q <= '0;
            armed_q <= 1'b0;
            idx_q   <= '0;
            base_q  <= '0;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            ie_q    <= ie_d;
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            irq_d_q <= irq_i;
            armed_q <= 1'b1;
            idx_q   <= idx_d;
            base_q  <= base_d;
            epc_q   <= epc_d;
        end
    end

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Scoreboard bench for cp0_irq_ctrl: stimulus queues expectations,
// a negedge monitor pops and compares them.
module tb_cp0_irq_ctrl;

    localparam int DATA_W  = 32;
    localparam int NUM_IRQ = 9;
    localparam int IDX_W   = 4;

    localparam int K_RD  = 0;
    localparam int K_REQ = 1;
    localparam int K_VEC = 2;
    localparam int K_EPC = 3;
    localparam int K_HND = 4;

    logic               clk;
    logic               rst;
    logic [NUM_IRQ-1:0] irq_i;
    logic [4:0]         c0_rd_addr;
    logic [DATA_W-1:0]  c0_r_data;
    logic [4:0]         c0_wr_addr;
    logic [DATA_W-1:0]  c0_w_data;
    logic               c0_reg_we;
    logic [31:0]        pc_i;
    logic               int_ack_i;
    logic               eret_i;
    logic               int_req_o;
    logic [31:0]        vector_o;
    logic [31:0]        epc_o;
    logic               in_handler_o;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    cp0_irq_ctrl #(
        .DATA_W (DATA_W),
        .NUM_IRQ(NUM_IRQ),
        .IDX_W  (IDX_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .irq_i       (irq_i),
        .c0_rd_addr  (c0_rd_addr),
        .c0_r_data   (c0_r_data),
        .c0_wr_addr  (c0_wr_addr),
        .c0_w_data   (c0_w_data),
        .c0_reg_we   (c0_reg_we),
        .pc_i        (pc_i),
        .int_ack_i   (int_ack_i),
        .eret_i      (eret_i),
        .int_req_o   (int_req_o),
        .vector_o    (vector_o),
        .epc_o       (epc_o),
        .in_handler_o(in_handler_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: everything queued before a negedge is compared there
    initial begin
        chk_t        e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.kind)
                    K_RD:    act = c0_r_data;
                    K_REQ:   act = {31'b0, int_req_o};
                    K_VEC:   act = vector_o;
                    K_EPC:   act = epc_o;
                    default: act = {31'b0, in_handler_o};
                endcase
                n_cmp++;
                if (act !== e.exp) begin
                    n_err++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input int kind, input logic [31:0] v, input string nm);
        chk_t e;
        e.kind = kind;
        e.exp  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] v, input string nm);
        c0_rd_addr = a;
        chk(K_RD, v, nm);
        step();
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        c0_wr_addr = a;
        c0_w_data  = d;
        c0_reg_we  = 1'b1;
        step();
        c0_reg_we  = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        irq_i      = '0;
        c0_rd_addr = '0;
        c0_wr_addr = '0;
        c0_w_data  = '0;
        c0_reg_we  = 1'b0;
        pc_i       = '0;
        int_ack_i  = 1'b0;
        eret_i     = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // reset state
        chk(K_REQ, 0, "rst_req");
        chk(K_VEC, 0, "rst_vec");
        chk(K_HND, 0, "rst_hnd");
        chk(K_EPC, 0, "rst_epc");
        rd(5'd11, 0, "rst_status");
        rd(5'd12, 0, "rst_base");
        rd(5'd13, 0, "rst_cause");
        rd(5'd14, 0, "rst_epcreg");
        rd(5'd5,  0, "rst_unmapped");

        // single source, request and acknowledge
        wr(5'd11, 32'h0000_0301);
        wr(5'd12, 32'h0000_1000);
        irq_i = 9'h002;
        step();
        irq_i = '0;
        chk(K_REQ, 1, "irq1_req");
        chk(K_VEC, 32'h1008, "irq1_vec");
        rd(5'd13, 32'h0000_0200, "irq1_pend");
        int_ack_i = 1'b1;
        pc_i      = 32'h400;
        step();
        int_ack_i = 1'b0;
        chk(K_EPC, 32'h400, "ack1_epc");
        chk(K_HND, 1, "ack1_hnd");
        chk(K_REQ, 0, "ack1_req");
        rd(5'd13, 32'h0000_0004, "ack1_cause");
        chk(K_VEC, 32'h1008, "ack1_vec_hold");
        rd(5'd11, 32'h0000_0300, "ack1_ie_clr");

        // return, then two simultaneous sources
        eret_i = 1'b1;
        step();
        eret_i = 1'b0;
        chk(K_HND, 0, "eret1_hnd");
        chk(K_REQ, 0, "eret1_req");
        rd(5'd11, 32'h0000_0301, "eret1_ie");
        wr(5'd11, 32'h0001_FF01);
        irq_i = 9'h024;
        step();
        irq_i = '0;
        chk(K_REQ, 1, "pri_req");
        chk(K_VEC, 32'h1010, "pri_vec2");
        rd(5'd13, 32'h0000_2404, "pri_pend");
        int_ack_i = 1'b1;
        pc_i      = 32'h500;
        step();
        int_ack_i = 1'b0;
        chk(K_HND, 1, "ack2_hnd");
        chk(K_EPC, 32'h500, "ack2_epc");
        chk(K_VEC, 32'h1010, "ack2_vec");
        chk(K_REQ, 0, "ack2_req");
        rd(5'd13, 32'h0000_2008, "ack2_cause");
        int_ack_i = 1'b1;
        pc_i      = 32'h999;
        step();
        int_ack_i = 1'b0;
        chk(K_EPC, 32'h500, "nest_epc");
        rd(5'd13, 32'h0000_2008, "nest_cause");

        // eret + STATUS write with IE=0: eret wins on IE
        eret_i = 1'b1;
        wr(5'd11, 32'h0001_FF00);
        eret_i = 1'b0;
        chk(K_HND, 0, "eret2_hnd");
        chk(K_REQ, 1, "eret2_req");
        chk(K_VEC, 32'h1028, "eret2_vec5");
        rd(5'd11, 32'h0001_FF01, "eret2_status");

        // ack + STATUS write with IE=1: ack wins on IE, MASK written
        int_ack_i = 1'b1;
        pc_i      = 32'h600;
        wr(5'd11, 32'h0000_FF01);
        int_ack_i = 1'b0;
        chk(K_EPC, 32'h600, "ack3_epc");
        chk(K_HND, 1, "ack3_hnd");
        rd(5'd11, 32'h0000_FF00, "ack3_status");
        rd(5'd13, 32'h0000_0014, "ack3_cause");
        eret_i = 1'b1;
        step();
        eret_i = 1'b0;
        chk(K_REQ, 0, "eret3_req");
        rd(5'd11, 32'h0000_FF01, "eret3_status");

        // masking and write-1-to-clear
        wr(5'd11, 32'h0000_0001);
        irq_i = 9'h008;
        step();
        irq_i = '0;
        chk(K_REQ, 0, "mask0_req");
        rd(5'd13, 32'h0000_0814, "mask0_pend");
        wr(5'd11, 32'h0000_0801);
        chk(K_REQ, 1, "mask3_req");
        chk(K_VEC, 32'h1018, "mask3_vec");
        rd(5'd11, 32'h0000_0801, "mask3_status");
        wr(5'd13, 32'h0000_083C);
        chk(K_REQ, 0, "w1c_req");
        rd(5'd13, 32'h0000_0014, "w1c_cause_idx");

        // clear vs same-cycle rise on line 8, and level held high
        irq_i = 9'h100;
        step();
        irq_i = '0;
        rd(5'd13, 32'h0001_0014, "p8_set");
        irq_i = 9'h100;
        wr(5'd13, 32'h0001_0000);
        rd(5'd13, 32'h0001_0014, "p8_rise_wins");
        wr(5'd13, 32'h0001_0000);
        rd(5'd13, 32'h0000_0014, "p8_level_clr");
        step();
        rd(5'd13, 32'h0000_0014, "p8_level_once");
        irq_i = '0;

        // BASE low bits, EPC write, unmapped write
        wr(5'd12, 32'h0000_2007);
        rd(5'd12, 32'h0000_2000, "base_lowbits");
        wr(5'd14, 32'hDEAD_BEEF);
        chk(K_EPC, 32'hDEAD_BEEF, "epc_wr_out");
        rd(5'd14, 32'hDEAD_BEEF, "epc_wr_rd");
        wr(5'd5, 32'hFFFF_FFFF);
        rd(5'd5, 0, "unmapped_wr");

        // ack + EPC write: pc_i wins
        wr(5'd11, 32'h0000_0301);
        irq_i = 9'h002;
        step();
        irq_i = '0;
        chk(K_REQ, 1, "h_req");
        chk(K_VEC, 32'h2008, "h_vec");
        rd(5'd13, 32'h0000_0214, "h_pend");
        int_ack_i = 1'b1;
        pc_i      = 32'h700;
        wr(5'd14, 32'h0000_1234);
        int_ack_i = 1'b0;
        chk(K_EPC, 32'h700, "ackepc_pc_wins");
        chk(K_HND, 1, "ackepc_hnd");
        rd(5'd13, 32'h0000_0004, "ackepc_cause");
        irq_i = 9'h001;
        step();
        irq_i = '0;
        chk(K_REQ, 0, "inh_req");
        rd(5'd13, 32'h0000_0104, "inh_pend0");

        // async reset mid-handler with line 2 held high
        irq_i = 9'h004;
        step();
        #2;
        rst = 1'b1;
        chk(K_HND, 0, "arst_hnd");
        chk(K_EPC, 0, "arst_epc");
        chk(K_REQ, 0, "arst_req");
        chk(K_VEC, 0, "arst_vec");
        rd(5'd13, 0, "arst_cause");
        step();
        rst = 1'b0;
        step();
        rd(5'd13, 0, "held_no_edge1");
        rd(5'd13, 0, "held_no_edge2");
        irq_i = '0;
        step();
        irq_i = 9'h004;
        step();
        irq_i = '0;
        rd(5'd13, 32'h0000_0400, "reedge_pend");

        step();
        step();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
